seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Scan controller for the 4-digit seven-segment display path. It holds a tear-free copy of the 12-bit BCD value and drives the 2-bit digit select into the downstream BCD digit mux. It generates active-low anode enables with leading-zero blanking and an anti-ghosting dead time between digits. It sits between the value producer (binary-to-BCD stage / UART vending logic) and the digit mux and segment decoder.

Parameters:
REFRESH_DIV, 100000, clk cycles each digit is lit, including dead time; minimum BLANK_CYCLES+2.
BLANK_CYCLES, 16, cycles at the start of each digit slot with all anodes off; minimum 1.
SHOW_D3, 0, 1 lights digit 3, which the mux forces to 0; 0 keeps it dark.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = scan display; 0 = display off
load  in  1  one-cycle strobe: capture value_bcd
value_bcd  in  12  {hundreds, tens, ones} BCD nibbles
blank_lead  in  1  1 = suppress leading zeros
display_bcd  out  12  registered value fed to the digit mux data input
select  out  2  digit index fed to the digit mux select
anode_n  out  4  active-low anode enables, bit i = digit i
frame_tick  out  1  one-cycle pulse when select wraps 3->0

Behaviour:
- Reset (async, active-high) state: OFF; select=0; anode_n=4'b1111; display_bcd=0; pending=0; prescaler=0; frame_tick=0. All outputs are registered.
- Load path: load=1 writes value_bcd into the pending register in any state. A new load overwrites an uncommitted pending value (last wins). Nibbles >9 pass through unchanged.
- States:
  - OFF: anode_n=1111, select=0, prescaler held 0.
  - DEAD: anodes off for BLANK_CYCLES.
  - LIT: the selected anode is driven.
- Transitions:
  - OFF->DEAD when enable=1; display_bcd<=pending on that same edge.
  - DEAD->LIT when prescaler == BLANK_CYCLES-1.
  - LIT->DEAD when prescaler == REFRESH_DIV-1; prescaler<=0 and select<=select+1 (mod 4).
  - Any state->OFF when enable=0, next edge: anode_n<=1111, select<=0, prescaler<=0.
- Frame boundary: the LIT->DEAD edge where select goes 3->0.
  - display_bcd<=pending on this edge.
  - frame_tick=1 for exactly that cycle.
  - If load is coincident with the boundary, display_bcd takes value_bcd directly (bypass).
  - display_bcd never changes mid-frame.
- Blanking in LIT, based on display_bcd:
  - digit 0 is always lit.
  - digit 1 is dark if blank_lead & hundreds==0 & tens==0.
  - digit 2 is dark if blank_lead & hundreds==0.
  - digit 3 is dark unless SHOW_D3=1.
  - A dark digit keeps its time slot (constant brightness).
- anode_n is registered and aligned with select: it is never active for a digit other than the current select. In DEAD, select already holds the new index.
- Latency: load to visible value is at most 1 frame + 1 cycle = 4*REFRESH_DIV+1 cycles.
- Reset asserted mid-scan forces the reset state immediately, with no completion of the current slot.

Decomposition:
- Shared display package holds:
  - NUM_DIGITS=4 and DIGIT_SEL_W=2.
  - State encoding OFF=2'd0, DEAD=2'd1, LIT=2'd2.
  - ANODES_OFF=4'b1111.
- One natural sub-module: scan_prescaler. It is the free-running 0..REFRESH_DIV-1 counter with sync clear and emits wrap and dead_done strobes.
- Blanking logic and state machine stay in seg_scan_ctrl.

Test Plan:
Simulation settings: REFRESH_DIV=8, BLANK_CYCLES=2.
1. Reset, then enable=1, load 12'h123, blank_lead=0. Required response:
   - First frame shows 000; from the next frame, display_bcd=12'h123.
   - select cycles 0,1,2,3 at 8 cycles each.
   - anode_n = 1110 / 1101 / 1011 for 6 cycles each after 2 dead cycles; 1111 during select=3.
   - frame_tick period = 32 cycles.
2. Load 12'h007, blank_lead=1. Required response: anode_n is 1110 only during select=0; select=1 and select=2 slots stay 1111.
3. Load 12'h050 at mid-frame, then 12'h051 before the boundary. Required response: display_bcd switches once, exactly at the frame_tick cycle, to 12'h051.
4. load coincident with the frame-boundary edge. Required response: display_bcd equals that cycle's value_bcd.
5. enable dropped during LIT of select=2. Required response:
   - Next edge: anode_n=1111, select=0.
   - On re-enable: DEAD first, display_bcd = latest pending.
6. Async reset pulsed between clock edges mid-LIT. Required response:
   - Outputs go to reset values before the next clk edge.
   - Scanning resumes from select=0 after release.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the 4-digit seven-segment scan path: widths, state
// encoding and the leading-zero blanking rule.
package seg_scan_ctrl_pkg;

    localparam int unsigned NUM_DIGITS  = 4;
    localparam int unsigned DIGIT_SEL_W = 2;
    localparam int unsigned BCD_W       = 12;

    localparam logic [NUM_DIGITS-1:0] ANODES_OFF = 4'b1111;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_DEAD = 2'd1,
        ST_LIT  = 2'd2
    } scan_state_t;

    // Digit 0 always shows; digits 1/2 hide as leading zeros; digit 3 is optional.
    function automatic logic digit_shown(
        input logic [DIGIT_SEL_W-1:0] idx,
        input logic [BCD_W-1:0]       bcd,
        input logic                   blank_lead,
        input logic                   show_d3
    );
        logic w_shown;
        w_shown = 1'b1;
        case (idx)
            2'd1:    w_shown = !(blank_lead && (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0));
            2'd2:    w_shown = !(blank_lead && (bcd[11:8] == 4'd0));
            2'd3:    w_shown = show_d3;
            default: w_shown = 1'b1;
        endcase
        return w_shown;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] anode_onehot_n(input logic [DIGIT_SEL_W-1:0] idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_scan_prescaler.sv
// Free-running slot counter 0..REFRESH_DIV-1 with synchronous clear; flags the
// last cycle of a slot and the last cycle of the dead time.
module seg_scan_ctrl_scan_prescaler #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    output logic o_wrap_c,
    output logic o_dead_done_c
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CNT_W-1:0] r_count;

    assign o_wrap_c      = (r_count == CNT_W'(REFRESH_DIV - 1));
    assign o_dead_done_c = (r_count == CNT_W'(BLANK_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear || o_wrap_c) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: tear-free display value, digit select,
// active-low anodes with leading-zero blanking and inter-digit dead time.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter bit          SHOW_D3      = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        load,
    input  logic [11:0] value_bcd,
    input  logic        blank_lead,
    output logic [11:0] display_bcd,
    output logic [1:0]  select,
    output logic [3:0]  anode_n,
    output logic        frame_tick
);

    scan_state_t r_state, w_next_state;

    logic [BCD_W-1:0]       r_pending;
    logic [BCD_W-1:0]       r_display, w_next_display;
    logic [DIGIT_SEL_W-1:0] r_select, w_next_select;
    logic [NUM_DIGITS-1:0]  r_anode_n, w_next_anode_n;
    logic                   r_tick, w_next_tick;

    logic                   w_wrap;
    logic                   w_dead_done;
    logic                   w_prescale_clear;
    logic [NUM_DIGITS-1:0]  w_anode_lit;

    // Counter sits at 0 while off so every scan starts with a full dead time.
    assign w_prescale_clear = !enable || (r_state == ST_OFF);

    seg_scan_ctrl_scan_prescaler #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_scan_prescaler (
        .clk           (clk),
        .reset         (reset),
        .i_clear       (w_prescale_clear),
        .o_wrap_c      (w_wrap),
        .o_dead_done_c (w_dead_done)
    );

    assign w_anode_lit = digit_shown(r_select, r_display, blank_lead, SHOW_D3)
                       ? anode_onehot_n(r_select) : ANODES_OFF;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
        end else if (load) begin
            r_pending <= value_bcd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_OFF;
            r_display <= '0;
            r_select  <= '0;
            r_anode_n <= ANODES_OFF;
            r_tick    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_display <= w_next_display;
            r_select  <= w_next_select;
            r_anode_n <= w_next_anode_n;
            r_tick    <= w_next_tick;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_next_display = r_display;
        w_next_select  = r_select;
        w_next_anode_n = ANODES_OFF;
        w_next_tick    = 1'b0;

        case (r_state)
            ST_OFF: begin
                if (enable) begin
                    w_next_state   = ST_DEAD;
                    w_next_display = r_pending;
                end
            end
            ST_DEAD: begin
                if (w_dead_done) begin
                    w_next_state   = ST_LIT;
                    w_next_anode_n = w_anode_lit;
                end
            end
            ST_LIT: begin
                if (w_wrap) begin
                    w_next_state  = ST_DEAD;
                    w_next_select = r_select + DIGIT_SEL_W'(1);
                    // Frame boundary: the only point the displayed value may change.
                    if (r_select == DIGIT_SEL_W'(NUM_DIGITS - 1)) begin
                        w_next_tick    = 1'b1;
                        w_next_display = load ? value_bcd : r_pending;
                    end
                end else begin
                    w_next_anode_n = w_anode_lit;
                end
            end
            default: begin
                w_next_state = ST_OFF;
            end
        endcase

        if (!enable) begin
            w_next_state   = ST_OFF;
            w_next_select  = '0;
            w_next_anode_n = ANODES_OFF;
            w_next_tick    = 1'b0;
            w_next_display = r_display;
        end
    end

    assign display_bcd = r_display;
    assign select      = r_select;
    assign anode_n     = r_anode_n;
    assign frame_tick  = r_tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: blanking table, directed corner sequences and a
// randomized run, all checked against a time-based reference model.
module tb_seg_scan_ctrl;

    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 4 * RD;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load;
    logic [11:0] value_bcd;
    logic        blank_lead;
    logic [11:0] display_bcd;
    logic [1:0]  select;
    logic [3:0]  anode_n;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;

    // Reference model: scan time since enable, plus pending/display values.
    bit          m_on;
    int          m_t;
    logic [11:0] m_pend;
    logic [11:0] m_disp;
    logic [1:0]  e_sel;
    logic [3:0]  e_an;
    logic        e_tick;

    typedef struct packed {
        logic [11:0]     value;
        logic            bl;
        logic [3:0][3:0] an;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC),
        .SHOW_D3      (1'b0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .load        (load),
        .value_bcd   (value_bcd),
        .blank_lead  (blank_lead),
        .display_bcd (display_bcd),
        .select      (select),
        .anode_n     (anode_n),
        .frame_tick  (frame_tick)
    );

    function automatic bit shown(input int d, input logic [11:0] v, input logic bl);
        if (d == 0) return 1'b1;
        if (d == 1) return !(bl && v[11:8] == 4'd0 && v[7:4] == 4'd0);
        if (d == 2) return !(bl && v[11:8] == 4'd0);
        return 1'b0;
    endfunction

    function automatic logic [3:0] rnd_nib();
        if ($urandom_range(0, 1) == 0) return 4'd0;
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic model_reset();
        m_on = 1'b0; m_t = 0; m_pend = '0; m_disp = '0;
        e_sel = '0; e_an = 4'hF; e_tick = 1'b0;
    endtask

    task automatic model_step(input logic r, input logic e, input logic l,
                              input logic [11:0] v, input logic bl);
        logic [11:0] old_pend;
        int slot;
        int ph;
        if (r) begin
            model_reset();
            return;
        end
        old_pend = m_pend;
        if (l) m_pend = v;
        if (!e) begin
            m_on = 1'b0;
            m_t  = 0;
        end else if (!m_on) begin
            m_on   = 1'b1;
            m_t    = 0;
            m_disp = old_pend;
        end else begin
            m_t++;
            if (m_t % FRAME == 0) m_disp = l ? v : old_pend;
        end
        e_sel = '0; e_an = 4'hF; e_tick = 1'b0;
        if (m_on) begin
            slot  = (m_t / RD) % 4;
            ph    = m_t % RD;
            e_sel = 2'(slot);
            if (ph >= BC && shown(slot, m_disp, bl)) e_an[slot] = 1'b0;
            e_tick = (m_t > 0) && (m_t % FRAME == 0);
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic check_model();
        total++;
        if (display_bcd !== m_disp || select !== e_sel || anode_n !== e_an || frame_tick !== e_tick) begin
            bad++;
            $display("FAIL model t=%0d: got disp=%h sel=%0d an=%b tick=%b want disp=%h sel=%0d an=%b tick=%b",
                     m_t, display_bcd, select, anode_n, frame_tick, m_disp, e_sel, e_an, e_tick);
        end
    endtask

    task automatic step();
        logic r, e, l, b;
        logic [11:0] v;
        r = reset; e = enable; l = load; b = blank_lead; v = value_bcd;
        @(posedge clk);
        model_step(r, e, l, v, b);
        #1;
        check_model();
    endtask

    task automatic run_to(input int slot, input int ph);
        for (int n = 0; n < 2 * FRAME; n++) begin
            if (m_on && ((m_t / RD) % 4) == slot && (m_t % RD) == ph) return;
            step();
        end
        total++; bad++;
        $display("FAIL run_to: slot %0d phase %0d not reached", slot, ph);
    endtask

    task automatic wait_tick();
        for (int n = 0; n < 2 * FRAME; n++) begin
            if (m_on && m_t > 0 && (m_t % FRAME) == 0) return;
            step();
        end
        total++; bad++;
        $display("FAIL wait_tick: no frame boundary within %0d cycles", 2 * FRAME);
    endtask

    initial begin
        bit got_tick;
        vecs[0] = '{12'h123, 1'b0, {4'b1111, 4'b1011, 4'b1101, 4'b1110}};
        vecs[1] = '{12'h007, 1'b1, {4'b1111, 4'b1111, 4'b1111, 4'b1110}};
        vecs[2] = '{12'h050, 1'b1, {4'b1111, 4'b1111, 4'b1101, 4'b1110}};
        vecs[3] = '{12'h000, 1'b1, {4'b1111, 4'b1111, 4'b1111, 4'b1110}};
        vecs[4] = '{12'h000, 1'b0, {4'b1111, 4'b1011, 4'b1101, 4'b1110}};
        vecs[5] = '{12'h900, 1'b1, {4'b1111, 4'b1011, 4'b1101, 4'b1110}};
        vecs[6] = '{12'h0A0, 1'b1, {4'b1111, 4'b1111, 4'b1101, 4'b1110}};

        reset = 1'b1; enable = 1'b0; load = 1'b0; value_bcd = '0; blank_lead = 1'b0;
        model_reset();
        repeat (3) step();
        check("rst_display", 32'(display_bcd), 32'h0);
        check("rst_select",  32'(select),      32'h0);
        check("rst_anode",   32'(anode_n),     32'hF);
        check("rst_tick",    32'(frame_tick),  32'h0);
        reset = 1'b0;
        step();

        // Blanking table: load, wait for the boundary, sample mid-LIT of every slot.
        for (int i = 0; i < 7; i++) begin
            value_bcd = vecs[i].value; blank_lead = vecs[i].bl; load = 1'b1; enable = 1'b1;
            step();
            load = 1'b0;
            if (i == 0) check("first_frame_zero", 32'(display_bcd), 32'h0);
            wait_tick();
            check("frame_value", 32'(display_bcd), 32'(vecs[i].value));
            check("tick_at_boundary", 32'(frame_tick), 32'h1);
            for (int s = 0; s < 4; s++) begin
                repeat (4) step();
                check("slot_select", 32'(select), 32'(s));
                check("blank_anode", 32'(anode_n), 32'(vecs[i].an[s]));
                repeat (4) step();
            end
            check("tick_period", 32'(frame_tick), 32'h1);
        end

        // Two loads inside one frame: last wins, switch only at the boundary.
        repeat (10) step();
        value_bcd = 12'h050; load = 1'b1; step(); load = 1'b0;
        repeat (5) step();
        value_bcd = 12'h051; load = 1'b1; step(); load = 1'b0;
        got_tick = 1'b0;
        for (int n = 0; n < 2 * FRAME; n++) begin
            step();
            if (e_tick) begin
                check("switch_at_tick", 32'(display_bcd), 32'h051);
                got_tick = 1'b1;
                break;
            end
            check("no_midframe_change", 32'(display_bcd), 32'h0A0);
        end
        if (!got_tick) begin
            total++; bad++;
            $display("FAIL switch_at_tick: boundary never reached");
        end

        // Load coincident with the boundary edge bypasses pending.
        run_to(3, RD - 1);
        value_bcd = 12'h456; load = 1'b1; step(); load = 1'b0;
        check("bypass_display", 32'(display_bcd), 32'h456);
        check("bypass_tick",    32'(frame_tick),  32'h1);

        // Enable dropped during LIT of digit 2, then re-enabled.
        run_to(2, 4);
        enable = 1'b0; step();
        check("off_anode",  32'(anode_n), 32'hF);
        check("off_select", 32'(select),  32'h0);
        value_bcd = 12'h789; load = 1'b1; step(); load = 1'b0;
        step();
        enable = 1'b1; step();
        check("reenable_display", 32'(display_bcd), 32'h789);
        check("reenable_dead",    32'(anode_n),     32'hF);
        check("reenable_select",  32'(select),      32'h0);
        step();
        check("reenable_dead2", 32'(anode_n), 32'hF);
        step();
        check("reenable_lit", 32'(anode_n), 32'hE);

        // Async reset pulsed between edges mid-LIT.
        run_to(1, 4);
        #2 reset = 1'b1;
        #1;
        check("async_rst_display", 32'(display_bcd), 32'h0);
        check("async_rst_select",  32'(select),      32'h0);
        check("async_rst_anode",   32'(anode_n),     32'hF);
        check("async_rst_tick",    32'(frame_tick),  32'h0);
        model_reset();
        #1 reset = 1'b0;
        step();
        check("resume_select", 32'(select),  32'h0);
        check("resume_anode",  32'(anode_n), 32'hF);
        run_to(0, BC);
        check("resume_lit", 32'(anode_n), 32'hE);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            if (enable) enable = ($urandom_range(0, 79) != 0);
            else        enable = ($urandom_range(0, 3) == 0);
            load = ($urandom_range(0, 7) == 0);
            value_bcd = {rnd_nib(), rnd_nib(), rnd_nib()};
            if ($urandom_range(0, 49) == 0) blank_lead = ~blank_lead;
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0; load = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
